// File: rtl/seven_segment_reader.sv
// seven_segment_reader: observes a multiplexed active-low 7-segment bus,
// debounces scan transitions with a match counter, decodes the glyph of the
// enabled digit and assembles complete frames of digit values.
//
// state  | meaning
// TRACK  | sample changing or still counting (cnt < STABLE_CYCLES-1)
// ARMED  | one more identical sample triggers the capture
// LOCKED | pattern already captured; hold without re-capturing
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   digit_value,
    output logic [DIGITS-1:0]     digit_blank,
    output logic [4*DIGITS-1:0]   frame_value,
    output logic                  frame_valid,
    output logic                  decode_error,
    output logic [7:0]            err_count
);

    localparam int SW = DIGITS + 7;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {TRACK, ARMED, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         s_q;
    logic [7:0]            cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   digit_value_q, digit_value_d;
    logic [DIGITS-1:0]     digit_blank_q, digit_blank_d;
    logic [4*DIGITS-1:0]   frame_value_q, frame_value_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  decode_error_q, decode_error_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [DIGITS-1:0]     seen_q, seen_d;

    logic [SW-1:0]         sample;
    logic                  same;
    logic                  capture;
    logic [DIGITS-1:0]     an_low;
    logic                  one_hot;
    logic [4:0]            glyph;

    // Returns {legal, value}; blank decodes to value 4'hF.
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'b1000000: r = {1'b1, 4'd0};
            7'b1111001: r = {1'b1, 4'd1};
            7'b0100100: r = {1'b1, 4'd2};
            7'b0110000: r = {1'b1, 4'd3};
            7'b0011001: r = {1'b1, 4'd4};
            7'b0010010: r = {1'b1, 4'd5};
            7'b0000010: r = {1'b1, 4'd6};
            7'b1111000: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0010000: r = {1'b1, 4'd9};
            7'b1111111: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    assign sample  = {an_in, seg_in};
    assign same    = (sample == s_q);
    assign an_low  = ~s_q[SW-1:7];
    assign one_hot = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
    assign glyph   = decode_glyph(s_q[6:0]);
    assign capture = (state_q == ARMED) && same;

    // Match counter and FSM next state; the state mirrors where cnt lands.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = TRACK;
        if (!same) begin
            cnt_d = 8'd1;
        end else if (cnt_q >= CNT_MAX) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        if (cnt_d == CNT_MAX) begin
            state_d = LOCKED;
        end else if (cnt_d == CNT_ARM) begin
            state_d = ARMED;
        end
    end

    // Capture handling: digit update, frame assembly and error accounting.
    always_comb begin
        digit_value_d  = digit_value_q;
        digit_blank_d  = digit_blank_q;
        frame_value_d  = frame_value_q;
        seen_d         = seen_q;
        frame_valid_d  = 1'b0;
        decode_error_d = 1'b0;
        err_count_d    = err_count_q;
        if (capture && (an_low != '0)) begin
            if (one_hot && glyph[4]) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (an_low[i]) begin
                        digit_value_d[4*i +: 4] = glyph[3:0];
                        digit_blank_d[i]        = (glyph[3:0] == 4'hF);
                        seen_d[i]               = 1'b1;
                    end
                end
                if (&seen_d) begin
                    frame_value_d = digit_value_d;
                    frame_valid_d = 1'b1;
                    seen_d        = '0;
                end
            end else begin
                decode_error_d = 1'b1;
            end
        end
        if (decode_error_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= TRACK;
            s_q            <= '1;
            cnt_q          <= 8'd0;
            digit_value_q  <= '1;
            digit_blank_q  <= '1;
            frame_value_q  <= '1;
            frame_valid_q  <= 1'b0;
            decode_error_q <= 1'b0;
            err_count_q    <= 8'd0;
            seen_q         <= '0;
        end else begin
            state_q        <= state_d;
            s_q            <= sample;
            cnt_q          <= cnt_d;
            digit_value_q  <= digit_value_d;
            digit_blank_q  <= digit_blank_d;
            frame_value_q  <= frame_value_d;
            frame_valid_q  <= frame_valid_d;
            decode_error_q <= decode_error_d;
            err_count_q    <= err_count_d;
            seen_q         <= seen_d;
        end
    end

    assign digit_value  = digit_value_q;
    assign digit_blank  = digit_blank_q;
    assign frame_value  = frame_value_q;
    assign frame_valid  = frame_valid_q;
    assign decode_error = decode_error_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: directed scenarios plus a randomized run
// checked against a run-length based reference model.
module tb_seven_segment_reader;

    localparam int D  = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_in = 7'h7F;
    logic [D-1:0]  an_in = '1;
    logic [4*D-1:0] digit_value, frame_value;
    logic [D-1:0]  digit_blank;
    logic          frame_valid, decode_error;
    logic [7:0]    err_count;

    int vectors = 0;
    int miscompares = 0;

    seven_segment_reader #(.DIGITS(D), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .digit_value(digit_value), .digit_blank(digit_blank),
        .frame_value(frame_value), .frame_valid(frame_valid),
        .decode_error(decode_error), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // glyphs for 0..9 then blank
    logic [6:0] tbl [0:10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b1111111};

    // reference model state
    logic [D+6:0] m_prev;
    int           m_run;
    logic [3:0]   m_dv [D];
    logic [3:0]   m_fv [D];
    logic [D-1:0] m_blank, m_seen;
    logic         m_fvalid, m_derr;
    int           m_errs;

    function automatic int glyph_val(input logic [6:0] g);
        for (int k = 0; k < 11; k++) if (tbl[k] == g) return (k == 10) ? 15 : k;
        return -1;
    endfunction

    function automatic logic [4*D-1:0] pack(input logic [3:0] a [D]);
        logic [4*D-1:0] r;
        for (int k = 0; k < D; k++) r[4*k +: 4] = a[k];
        return r;
    endfunction

    task automatic model_edge();
        logic [D+6:0] smp;
        int nlow, idx, v;
        m_fvalid = 1'b0;
        m_derr   = 1'b0;
        if (rst) begin
            m_prev = '1; m_run = 0; m_blank = '1; m_seen = '0; m_errs = 0;
            for (int k = 0; k < D; k++) begin m_dv[k] = 4'hF; m_fv[k] = 4'hF; end
            return;
        end
        smp = {an_in, seg_in};
        if (smp == m_prev) begin
            if (m_run < SC) begin
                m_run++;
                if (m_run == SC) begin
                    nlow = 0; idx = 0;
                    for (int k = 0; k < D; k++) if (!smp[7+k]) begin nlow++; idx = k; end
                    v = glyph_val(smp[6:0]);
                    if (nlow == 1 && v >= 0) begin
                        m_dv[idx] = 4'(v);
                        m_blank[idx] = (v == 15);
                        m_seen[idx] = 1'b1;
                        if (m_seen == '1) begin
                            m_fv = m_dv; m_fvalid = 1'b1; m_seen = '0;
                        end
                    end else if (nlow > 0) begin
                        m_derr = 1'b1;
                        if (m_errs < 255) m_errs++;
                    end
                end
            end
        end else begin
            m_run = 1;
        end
        m_prev = smp;
    endtask

    task automatic cycle(input logic [D-1:0] an, input logic [6:0] seg);
        an_in = an; seg_in = seg;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle('1, 7'h7F);
        cycle('1, 7'h7F);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (digit_value !== 16'hFFFF) begin miscompares++; $display("FAIL reset_dv got %h want ffff", digit_value); end
        vectors++;
        if (digit_blank !== 4'hF || frame_value !== 16'hFFFF || frame_valid !== 1'b0 ||
            decode_error !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_misc got blank=%h fv=%h fval=%b derr=%b errs=%0d want F FFFF 0 0 0",
                     digit_blank, frame_value, frame_valid, decode_error, err_count);
        end
    endtask

    task automatic test_single_digit();
        int pulses = 0;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle(4'b1110, 7'b0100100);
            if (frame_valid) pulses++;
            if (k == 3) begin
                vectors++;
                if (digit_value[3:0] !== 4'hF) begin miscompares++; $display("FAIL single_early got %h want f", digit_value[3:0]); end
            end
            if (k >= 4) begin
                vectors++;
                if (digit_value[3:0] !== 4'd2 || digit_blank[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_cap cyc%0d got %h blank=%b want 2 blank=0", k, digit_value[3:0], digit_blank[0]);
                end
            end
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL single_noframe got %0d pulses want 0", pulses); end
    endtask

    task automatic test_frame();
        int pulses = 0;
        logic [6:0] g [4] = '{7'b1111001, 7'b0110000, 7'b0010010, 7'b0010000};
        do_reset();
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 6; k++) begin
                cycle(~(4'b1 << d), g[d]);
                if (frame_valid) pulses++;
            end
        vectors++;
        if (pulses !== 1) begin miscompares++; $display("FAIL frame_pulses got %0d want 1", pulses); end
        vectors++;
        if (frame_value !== 16'h9531) begin miscompares++; $display("FAIL frame_value got %h want 9531", frame_value); end
        // seen must be clear: three more digits alone must not complete a frame
        pulses = 0;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 6; k++) begin
                cycle(~(4'b1 << d), g[d]);
                if (frame_valid) pulses++;
            end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL frame_seen_clear got %0d pulses want 0", pulses); end
    endtask

    task automatic test_glitch();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 6; k++) cycle(4'b1101, 7'b0000000);
        vectors++;
        if (digit_value[7:4] !== 4'd8) begin miscompares++; $display("FAIL glitch_pre got %h want 8", digit_value[7:4]); end
        for (int k = 0; k < 2; k++) begin
            cycle(4'b1101, 7'b1111111);
            if (digit_value[7:4] !== 4'd8 || digit_blank[1] !== 1'b0) bad++;
        end
        for (int k = 0; k < 6; k++) begin
            cycle(4'b1101, 7'b0000000);
            if (digit_value[7:4] !== 4'd8 || digit_blank[1] !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL glitch_hold got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_errors();
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin cycle(4'b1100, 7'b1111001); if (decode_error) pulses++; end
        for (int k = 0; k < 6; k++) begin cycle(4'b1110, 7'b0101010); if (decode_error) pulses++; end
        vectors++;
        if (pulses !== 2) begin miscompares++; $display("FAIL err_pulses got %0d want 2", pulses); end
        vectors++;
        if (err_count !== 8'd2) begin miscompares++; $display("FAIL err_count got %0d want 2", err_count); end
        vectors++;
        if (digit_value !== 16'hFFFF) begin miscompares++; $display("FAIL err_dv got %h want ffff", digit_value); end
    endtask

    task automatic test_blank();
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 6; k++) cycle(4'b1011, 7'b1111000);
        vectors++;
        if (digit_value[11:8] !== 4'd7 || digit_blank[2] !== 1'b0) begin
            miscompares++; $display("FAIL blank_pre got %h/%b want 7/0", digit_value[11:8], digit_blank[2]);
        end
        for (int k = 0; k < 6; k++) cycle(4'b1011, 7'b1111111);
        vectors++;
        if (digit_value[11:8] !== 4'hF || digit_blank[2] !== 1'b1) begin
            miscompares++; $display("FAIL blank_cap got %h/%b want f/1", digit_value[11:8], digit_blank[2]);
        end
        for (int k = 0; k < 6; k++) begin cycle(4'b1110, tbl[6]); if (frame_valid) pulses++; end
        for (int k = 0; k < 6; k++) begin cycle(4'b1101, tbl[0]); if (frame_valid) pulses++; end
        for (int k = 0; k < 6; k++) begin cycle(4'b0111, tbl[4]); if (frame_valid) pulses++; end
        vectors++;
        if (pulses !== 1 || frame_value !== 16'h4F06) begin
            miscompares++; $display("FAIL blank_frame got %0d pulses fv=%h want 1 4f06", pulses, frame_value);
        end
    endtask

    task automatic test_reset_midframe();
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 4; k++) cycle(4'b1110, tbl[4]);
        vectors++;
        if (digit_value[3:0] !== 4'd4) begin miscompares++; $display("FAIL mid_cap got %h want 4", digit_value[3:0]); end
        rst = 1'b1;
        cycle(4'b1110, tbl[4]);
        rst = 1'b0;
        vectors++;
        if (digit_value !== 16'hFFFF || digit_blank !== 4'hF || frame_value !== 16'hFFFF ||
            frame_valid !== 1'b0 || decode_error !== 1'b0 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset got dv=%h bl=%h fv=%h want ffff f ffff", digit_value, digit_blank, frame_value);
        end
        for (int d = 1; d < 4; d++)
            for (int k = 0; k < 6; k++) begin cycle(~(4'b1 << d), tbl[d]); if (frame_valid) pulses++; end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL mid_noframe got %0d want 0", pulses); end
        for (int k = 0; k < 6; k++) begin cycle(4'b1110, tbl[4]); if (frame_valid) pulses++; end
        vectors++;
        if (pulses !== 1 || frame_value !== 16'h3214) begin
            miscompares++; $display("FAIL mid_frame got %0d pulses fv=%h want 1 3214", pulses, frame_value);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int e = 0; e < 270; e++)
            for (int k = 0; k < SC; k++) cycle(4'b0011, (e % 2 == 0) ? 7'h7F : tbl[3]);
        vectors++;
        if (err_count !== 8'd255) begin miscompares++; $display("FAIL err_sat got %0d want 255", err_count); end
    endtask

    task automatic test_random();
        logic [D-1:0] an;
        logic [6:0]   seg;
        int hold, bad = 0;
        do_reset();
        for (int p = 0; p < 700; p++) begin
            case ($urandom_range(0, 9))
                0:       an = '1;
                1, 2, 3, 4, 5, 6: an = ~(4'b1 << $urandom_range(0, 3));
                default: an = 4'($urandom);
            endcase
            seg  = ($urandom_range(0, 9) < 7) ? tbl[$urandom_range(0, 10)] : 7'($urandom);
            hold = $urandom_range(1, 7);
            rst  = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < hold; k++) begin
                cycle(an, seg);
                vectors++;
                if (digit_value !== pack(m_dv) || digit_blank !== m_blank ||
                    frame_value !== pack(m_fv) || frame_valid !== m_fvalid ||
                    decode_error !== m_derr || err_count !== 8'(m_errs)) begin
                    miscompares++;
                    if (bad < 10)
                        $display("FAIL rand p%0d got dv=%h bl=%h fv=%h fval=%b de=%b ec=%0d want %h %h %h %b %b %0d",
                                 p, digit_value, digit_blank, frame_value, frame_valid, decode_error, err_count,
                                 pack(m_dv), m_blank, pack(m_fv), m_fvalid, m_derr, m_errs);
                    bad++;
                end
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_frame();
        test_glitch();
        test_errors();
        test_blank();
        test_reset_midframe();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
